dmem_access_ctrl: RTL and testbench

Sequencer between the MEM stage of the RV32I pipeline and the word-wide data memory. It takes the decoded memory controls (enable, load/store, funct3) with the computed address and store data, and runs one handshaked memory transaction per access. It drives byte enables and lane-replicated store data, aligns and extends load data, and stalls the pipeline until the access retires. Misaligned accesses, illegal funct3 values and memory timeouts are reported as an error code instead of hanging the pipeline.

---
 rtl/dmem_access_ctrl.sv | 172 +++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences one handshaked data-memory transaction per
// MEM-stage load/store. It drives byte enables and lane-replicated store
// data, aligns and extends load data, stalls the pipeline until the access
// retires, and reports misaligned, illegal or timed-out accesses as errors.
module dmem_access_ctrl #(
    parameter int MAX_WAIT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en_dmem,
    input  logic        i_load_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic [1:0]  o_err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic [3:0]       be_q;
    logic [31:0]      addr_q, wdata_q, rdata_q;
    logic [2:0]       f3_q;
    logic [1:0]       off_q, err_q, req_err;
    logic             timeout;

    // Loads accept B/H/W/BU/HU; stores only B/H/W.
    function automatic logic f3_legal(input logic store, input logic [2:0] f3);
        if (store) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then sign- or zero-extend.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] word);
        logic [31:0] s;
        s = word >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return {24'd0, s[7:0]};
            3'b101:  return {16'd0, s[15:0]};
            default: return word;
        endcase
    endfunction

    // Illegal funct3 outranks misalignment.
    always_comb begin
        req_err = 2'd0;
        if (!f3_legal(i_load_store, i_funct3))       req_err = 2'd2;
        else if (misaligned(i_funct3, i_addr[1:0]))  req_err = 2'd1;
    end

    assign timeout = (state == BUSY) && !i_mem_ready && (cnt == CNT_MAX);

    // Next-state and stall decode.
    always_comb begin
        state_nxt = state;
        o_stall   = 1'b0;
        case (state)
            IDLE: if (i_en_dmem) begin
                o_stall   = 1'b1;
                state_nxt = (req_err != 2'd0) ? DONE : BUSY;
            end
            BUSY: begin
                o_stall = 1'b1;
                if (i_mem_ready || timeout) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Wait counter: counts unanswered BUSY cycles, zero everywhere else.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                                   cnt <= '0;
        else if (state == BUSY && state_nxt == BUSY)    cnt <= cnt + 1'b1;
        else                                            cnt <= '0;
    end

    // Latch the request on acceptance so memory outputs stay stable in BUSY.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            off_q   <= '0;
        end else if (state == IDLE && i_en_dmem && req_err == 2'd0) begin
            we_q    <= i_load_store;
            addr_q  <= {i_addr[31:2], 2'b00};
            be_q    <= lane_be(i_funct3, i_addr[1:0]);
            wdata_q <= lane_wdata(i_funct3, i_wdata);
            f3_q    <= i_funct3;
            off_q   <= i_addr[1:0];
        end
    end

    // Capture the result and error code presented during DONE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdata_q <= '0;
            err_q   <= '0;
        end else if (state == IDLE && i_en_dmem && req_err != 2'd0) begin
            rdata_q <= '0;
            err_q   <= req_err;
        end else if (state == BUSY && i_mem_ready) begin
            rdata_q <= we_q ? 32'd0 : load_extract(f3_q, off_q, i_mem_rdata);
            err_q   <= 2'd0;
        end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= 2'd3;
        end
    end

    assign o_mem_req   = (state == BUSY);
    assign o_mem_we    = (state == BUSY) && we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_be    = be_q;
    assign o_mem_wdata = wdata_q;
    assign o_done      = (state == DONE);
    assign o_rdata     = rdata_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed vector table, reset corner cases and
// randomized accesses checked against a rule-level reference model.
module tb_dmem_access_ctrl;

    localparam int MW = 3;

    logic        clk = 1'b0;
    logic        rst_n, en, ls, ready;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, mrdata;
    logic        mem_req, mem_we, stall, done;
    logic [31:0] mem_addr, mem_wdata, rdata;
    logic [3:0]  mem_be;
    logic [1:0]  err;

    int n_vec = 0;
    int n_err = 0;

    dmem_access_ctrl #(.MAX_WAIT(MW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en_dmem(en), .i_load_store(ls),
        .i_funct3(f3), .i_addr(addr), .i_wdata(wdata),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_be(mem_be), .o_mem_wdata(mem_wdata),
        .i_mem_ready(ready), .i_mem_rdata(mrdata),
        .o_stall(stall), .o_done(done), .o_rdata(rdata), .o_err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ls;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ready_at;   // BUSY cycle (1-based) with ready; 0 = never
        logic [1:0]  err;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model built from the access rules with plain arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int size, off;
        logic legal;
        logic [63:0] mask, val;
        r = v;
        size = 1 << v.f3[1:0];
        off = int'(v.addr % 4);
        legal = v.ls ? (v.f3 <= 3'd2) : (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        r.be = 4'(((1 << size) - 1) << off);
        r.wd = (size == 1) ? v.wdata[7:0] * 32'h01010101 :
               (size == 2) ? v.wdata[15:0] * 32'h00010001 : v.wdata;
        r.rd = 32'd0;
        if (!legal)                    r.err = 2'd2;
        else if ((v.addr % size) != 0) r.err = 2'd1;
        else if (v.ready_at >= 1 && v.ready_at <= MW + 1) begin
            r.err = 2'd0;
            if (!v.ls) begin
                val = 64'(v.rdata) >> (8 * off);
                mask = (64'd1 << (8 * size)) - 1;
                val = val & mask;
                if (!v.f3[2] && size < 4 && val[8*size-1]) val = val | ~mask;
                r.rd = val[31:0];
            end
        end else r.err = 2'd3;
        return r;
    endfunction

    // One access from IDLE through DONE, checking every cycle.
    task automatic run(input vec_t v);
        int exp_done, cyc;
        bit fin;
        exp_done = (v.err == 2'd1 || v.err == 2'd2) ? 1 :
                   (v.err == 2'd3) ? MW + 2 : v.ready_at + 1;
        @(posedge clk); #1;
        en = 1'b1; ls = v.ls; f3 = v.f3; addr = v.addr; wdata = v.wdata;
        mrdata = v.rdata; ready = 1'b0;
        @(negedge clk);
        chk("idle_stall", 32'(stall), 32'd1);
        chk("idle_req", 32'(mem_req), 32'd0);
        fin = 1'b0;
        for (cyc = 1; cyc <= 20 && !fin; cyc++) begin
            @(posedge clk); #1;
            ready = (cyc == v.ready_at);
            @(negedge clk);
            if (done) begin
                fin = 1'b1;
                chk("done_cycle", cyc, exp_done);
                chk("done_stall", 32'(stall), 32'd0);
                chk("done_req", 32'(mem_req), 32'd0);
                chk("err", 32'(err), 32'(v.err));
                chk("rdata", rdata, v.rd);
            end else begin
                chk("busy_req", 32'(mem_req), 32'd1);
                chk("busy_stall", 32'(stall), 32'd1);
                chk("busy_addr", mem_addr, {v.addr[31:2], 2'b00});
                chk("busy_be", 32'(mem_be), 32'(v.be));
                chk("busy_we", 32'(mem_we), 32'(v.ls));
                if (v.ls) chk("busy_wdata", mem_wdata, v.wd);
            end
        end
        if (!fin) chk("done_within_bound", 32'd0, 32'd1);
        ready = 1'b0;
    endtask

    vec_t tbl[14];
    vec_t rv;

    initial begin
        tbl[0]  = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        1, 2'd0, 4'hF,    32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1'b0, 3'b000, 32'h203, 32'h0,        32'h80FF1234, 1, 2'd0, 4'b1000, 32'h0,        32'hFFFFFF80};
        tbl[2]  = '{1'b0, 3'b100, 32'h203, 32'h0,        32'h80FF1234, 1, 2'd0, 4'b1000, 32'h0,        32'h00000080};
        tbl[3]  = '{1'b0, 3'b101, 32'h202, 32'h0,        32'h80FF1234, 2, 2'd0, 4'b1100, 32'h0,        32'h000080FF};
        tbl[4]  = '{1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0,        1, 2'd0, 4'b1100, 32'hABCDABCD, 32'h0};
        tbl[5]  = '{1'b1, 3'b000, 32'h101, 32'h0000005A, 32'h0,        1, 2'd0, 4'b0010, 32'h5A5A5A5A, 32'h0};
        tbl[6]  = '{1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        1, 2'd1, 4'h0,    32'h0,        32'h0};
        tbl[7]  = '{1'b1, 3'b100, 32'h100, 32'h0,        32'h0,        1, 2'd2, 4'h0,    32'h0,        32'h0};
        tbl[8]  = '{1'b0, 3'b010, 32'h300, 32'h0,        32'h12345678, 0, 2'd3, 4'hF,    32'h0,        32'h0};
        tbl[9]  = '{1'b0, 3'b010, 32'h300, 32'h0,        32'h12345678, 3, 2'd0, 4'hF,    32'h0,        32'h12345678};
        tbl[10] = '{1'b0, 3'b001, 32'h106, 32'h0,        32'h80010000, 1, 2'd0, 4'b1100, 32'h0,        32'hFFFF8001};
        tbl[11] = '{1'b0, 3'b010, 32'h400, 32'h0,        32'hCAFEF00D, 4, 2'd0, 4'hF,    32'h0,        32'hCAFEF00D};
        tbl[12] = '{1'b0, 3'b011, 32'h003, 32'h0,        32'h0,        1, 2'd2, 4'h0,    32'h0,        32'h0};
        tbl[13] = '{1'b1, 3'b001, 32'h101, 32'h0,        32'h0,        1, 2'd1, 4'h0,    32'h0,        32'h0};

        rst_n = 1'b0; en = 1'b0; ls = 1'b0; f3 = 3'b0; addr = '0; wdata = '0;
        ready = 1'b0; mrdata = '0;
        #12;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_stall_off", 32'(stall), 32'd0);
        en = 1'b1; #1;
        chk("rst_stall_on", 32'(stall), 32'd1);
        en = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run(tbl[i]);

        // Reset while BUSY: request and stall drop at once, no retire pulse.
        @(posedge clk); #1;
        en = 1'b1; ls = 1'b0; f3 = 3'b010; addr = 32'h500; ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        #2; rst_n = 1'b0; en = 1'b0; #1;
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("post_rst_no_done", 32'(done), 32'd0);
        end
        run('{1'b0, 3'b010, 32'h504, 32'h0, 32'h0BADF00D, 1, 2'd0, 4'hF, 32'h0, 32'h0BADF00D});

        // Randomized accesses checked against the model.
        for (int i = 0; i < 80; i++) begin
            rv.ls = 1'($urandom);
            rv.f3 = 3'($urandom);
            rv.addr = $urandom;
            rv.wdata = $urandom;
            rv.rdata = $urandom;
            rv.ready_at = $urandom_range(0, MW + 2);
            rv = model(rv);
            run(rv);
        end

        @(posedge clk); #1; en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
